// File: rtl/gfx256_pkg.sv
// Shared types and line geometry for the gfx256 read arbiter and its line buffer.
package gfx256_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } rd_arb_state_e;

    typedef enum logic {
        CLIENT_Z   = 1'b0,
        CLIENT_TEX = 1'b1
    } rd_client_e;

    localparam int LINE_BYTES = 32;
    localparam int OFFS_W     = $clog2(LINE_BYTES);
    localparam int TAG_W      = 32 - OFFS_W;

endpackage

// File: rtl/gfx256_line_buf.sv
// One-line read buffer: tag/valid/data register with lookup, fill, error drop and invalidate.
module gfx256_line_buf
    import gfx256_pkg::*;
#(
    parameter int   SW = 256,
    parameter logic EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [SW-1:0]    line_o,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [SW-1:0]    fill_data_i,
    input  logic             drop_i,
    input  logic [TAG_W-1:0] drop_tag_i,
    input  logic             inv_i
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [SW-1:0]    data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i;
            data_d  = fill_data_i;
        end else if (drop_i && (tag_q == drop_tag_i)) begin
            valid_d = 1'b0;
        end
        // An invalidate always wins, even over a same-cycle fill.
        if (inv_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = EN && valid_q && (tag_q == lookup_tag_i);
    assign line_o = data_q;

endmodule

// File: rtl/gfx256_wbm_read_arb.sv
// Round-robin read engine for the z and texture ports onto one 256-bit Wishbone classic bus.
module gfx256_wbm_read_arb
    import gfx256_pkg::*;
#(
    parameter int   SW          = 256,
    parameter logic LINE_BUF_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          z_request_i,
    input  logic [31:0]   z_addr_i,
    input  logic [31:0]   z_sel_i,
    output logic          z_ack_o,
    output logic [SW-1:0] z_data_o,
    input  logic          tex_request_i,
    input  logic [31:0]   tex_addr_i,
    input  logic [31:0]   tex_sel_i,
    output logic          tex_ack_o,
    output logic [SW-1:0] tex_data_o,
    input  logic          invalidate_i,
    output logic          busy_o,
    output logic          err_o,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [31:0]   adr_o,
    output logic [31:0]   sel_o,
    input  logic [SW-1:0] dat_i,
    input  logic          ack_i,
    input  logic          err_i
);

    rd_arb_state_e    state_q, state_d;
    rd_client_e       last_grant_q, last_grant_d;
    rd_client_e       client_q, client_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      sel_q, sel_d;
    logic             cyc_q, cyc_d;
    logic             z_ack_q, z_ack_d;
    logic             tex_ack_q, tex_ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [SW-1:0]    z_data_q, z_data_d;
    logic [SW-1:0]    tex_data_q, tex_data_d;

    rd_client_e       grant;
    logic [TAG_W-1:0] grant_tag;
    logic [31:0]      grant_sel;
    logic             buf_hit;
    logic [SW-1:0]    buf_line;
    logic             fill;
    logic             drop;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{z_addr_i[OFFS_W-1:0], tex_addr_i[OFFS_W-1:0]};

    always_comb begin
        if (z_request_i && tex_request_i) begin
            grant = (last_grant_q == CLIENT_TEX) ? CLIENT_Z : CLIENT_TEX;
        end else if (tex_request_i) begin
            grant = CLIENT_TEX;
        end else begin
            grant = CLIENT_Z;
        end
        grant_tag = (grant == CLIENT_TEX) ? tex_addr_i[31:OFFS_W] : z_addr_i[31:OFFS_W];
        grant_sel = (grant == CLIENT_TEX) ? tex_sel_i : z_sel_i;
    end

    gfx256_line_buf #(
        .SW (SW),
        .EN (LINE_BUF_EN)
    ) u_line_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .lookup_tag_i (grant_tag),
        .hit_o        (buf_hit),
        .line_o       (buf_line),
        .fill_i       (fill),
        .fill_tag_i   (tag_q),
        .fill_data_i  (dat_i),
        .drop_i       (drop),
        .drop_tag_i   (tag_q),
        .inv_i        (invalidate_i)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        client_d     = client_q;
        tag_d        = tag_q;
        sel_d        = sel_q;
        cyc_d        = cyc_q;
        z_ack_d      = 1'b0;
        tex_ack_d    = 1'b0;
        err_d        = 1'b0;
        z_data_d     = z_data_q;
        tex_data_d   = tex_data_q;
        fill         = 1'b0;
        drop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (z_request_i || tex_request_i) begin
                    client_d = grant;
                    tag_d    = grant_tag;
                    sel_d    = grant_sel;
                    // A same-cycle invalidate must turn a would-be hit into a miss.
                    if (buf_hit && !invalidate_i) begin
                        state_d = DONE;
                        if (grant == CLIENT_TEX) begin
                            tex_ack_d  = 1'b1;
                            tex_data_d = buf_line;
                        end else begin
                            z_ack_d  = 1'b1;
                            z_data_d = buf_line;
                        end
                    end else begin
                        cyc_d   = 1'b1;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (err_i) begin
                    cyc_d   = 1'b0;
                    drop    = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (client_q == CLIENT_TEX) begin
                        tex_ack_d  = 1'b1;
                        tex_data_d = '0;
                    end else begin
                        z_ack_d  = 1'b1;
                        z_data_d = '0;
                    end
                end else if (ack_i) begin
                    cyc_d   = 1'b0;
                    fill    = 1'b1;
                    state_d = DONE;
                    if (client_q == CLIENT_TEX) begin
                        tex_ack_d  = 1'b1;
                        tex_data_d = dat_i;
                    end else begin
                        z_ack_d  = 1'b1;
                        z_data_d = dat_i;
                    end
                end
            end
            DONE: begin
                last_grant_d = client_q;
                state_d      = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= CLIENT_TEX;
            client_q     <= CLIENT_Z;
            tag_q        <= '0;
            sel_q        <= '0;
            cyc_q        <= 1'b0;
            z_ack_q      <= 1'b0;
            tex_ack_q    <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            z_data_q     <= '0;
            tex_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            client_q     <= client_d;
            tag_q        <= tag_d;
            sel_q        <= sel_d;
            cyc_q        <= cyc_d;
            z_ack_q      <= z_ack_d;
            tex_ack_q    <= tex_ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            z_data_q     <= z_data_d;
            tex_data_q   <= tex_data_d;
        end
    end

    assign z_ack_o    = z_ack_q;
    assign tex_ack_o  = tex_ack_q;
    assign z_data_o   = z_data_q;
    assign tex_data_o = tex_data_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;
    assign cyc_o      = cyc_q;
    assign stb_o      = cyc_q;
    assign we_o       = 1'b0;
    assign adr_o      = {tag_q, {OFFS_W{1'b0}}};
    assign sel_o      = sel_q;

endmodule

// File: tb/tb_gfx256_wbm_read_arb.sv
// Scoreboard bench for gfx256_wbm_read_arb: expected acks queued at stimulus time, popped on DUT acks.
module tb_gfx256_wbm_read_arb;
    import gfx256_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         z_request_i = 1'b0;
    logic [31:0]  z_addr_i = '0;
    logic [31:0]  z_sel_i = '0;
    logic         z_ack_o;
    logic [255:0] z_data_o;
    logic         tex_request_i = 1'b0;
    logic [31:0]  tex_addr_i = '0;
    logic [31:0]  tex_sel_i = '0;
    logic         tex_ack_o;
    logic [255:0] tex_data_o;
    logic         invalidate_i = 1'b0;
    logic         busy_o;
    logic         err_o;
    logic         cyc_o;
    logic         stb_o;
    logic         we_o;
    logic [31:0]  adr_o;
    logic [31:0]  sel_o;
    logic [255:0] dat_i = '0;
    logic         ack_i = 1'b0;
    logic         err_i = 1'b0;

    always #5 clk_i = ~clk_i;

    gfx256_wbm_read_arb dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .z_request_i   (z_request_i),
        .z_addr_i      (z_addr_i),
        .z_sel_i       (z_sel_i),
        .z_ack_o       (z_ack_o),
        .z_data_o      (z_data_o),
        .tex_request_i (tex_request_i),
        .tex_addr_i    (tex_addr_i),
        .tex_sel_i     (tex_sel_i),
        .tex_ack_o     (tex_ack_o),
        .tex_data_o    (tex_data_o),
        .invalidate_i  (invalidate_i),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .cyc_o         (cyc_o),
        .stb_o         (stb_o),
        .we_o          (we_o),
        .adr_o         (adr_o),
        .sel_o         (sel_o),
        .dat_i         (dat_i),
        .ack_i         (ack_i),
        .err_i         (err_i)
    );

    typedef struct {
        logic         tex;
        logic [255:0] data;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [255:0] mon_data;
    logic [255:0] prev_z = '0;
    logic [255:0] prev_tex = '0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           z_ack_cnt = 0;
    int           tex_ack_cnt = 0;

    function automatic logic [255:0] pat(input logic [31:0] s);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = (s * 32'h9E37_79B9) + (k * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        return r;
    endfunction

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic tex, input logic [255:0] d, input logic err);
        exp_t e;
        e.tex  = tex;
        e.data = d;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            if (cyc_o === 1'b1 && stb_o === 1'b1) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL wait_stb: cyc_o=%b stb_o=%b, required both 1 within 50 cycles", cyc_o, stb_o);
        end
    endtask

    // Drives a bus termination after lat cycles of strobe; returns on the cycle the DUT ack is due.
    task automatic bus_respond(input int lat, input logic [255:0] d, input bit err, input bit inv);
        repeat (lat - 1) step();
        ack_i        = ~err;
        err_i        = err;
        dat_i        = d;
        invalidate_i = inv;
        step();
        ack_i        = 1'b0;
        err_i        = 1'b0;
        dat_i        = '0;
        invalidate_i = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per ack and guards the hold-data rules.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_z   = z_data_o;
            prev_tex = tex_data_o;
        end else begin
            n_checks++;
            if (!z_ack_o && z_data_o !== prev_z) begin
                n_errors++;
                $display("FAIL z_data_hold: z_data_o=%h changed without z_ack_o, required %h", z_data_o, prev_z);
            end
            n_checks++;
            if (!tex_ack_o && tex_data_o !== prev_tex) begin
                n_errors++;
                $display("FAIL tex_data_hold: tex_data_o=%h changed without tex_ack_o, required %h", tex_data_o, prev_tex);
            end
            n_checks++;
            if ((z_ack_o && tex_ack_o) || (err_o && !(z_ack_o || tex_ack_o))) begin
                n_errors++;
                $display("FAIL ack_pairing: z_ack=%b tex_ack=%b err=%b, required one ack at most and err only with ack",
                         z_ack_o, tex_ack_o, err_o);
            end
            if (z_ack_o || tex_ack_o) begin
                if (z_ack_o) z_ack_cnt++;
                if (tex_ack_o) tex_ack_cnt++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_ack: z_ack=%b tex_ack=%b, required no ack", z_ack_o, tex_ack_o);
                end else begin
                    mon_e    = sb.pop_front();
                    mon_data = tex_ack_o ? tex_data_o : z_data_o;
                    if (tex_ack_o !== mon_e.tex || mon_data !== mon_e.data || err_o !== mon_e.err) begin
                        n_errors++;
                        $display("FAIL sb_ack: tex=%b err=%b data=%h, required tex=%b err=%b data=%h",
                                 tex_ack_o, err_o, mon_data, mon_e.tex, mon_e.err, mon_e.data);
                    end
                end
            end
            prev_z   = z_data_o;
            prev_tex = tex_data_o;
        end
    end

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({cyc_o, stb_o, we_o, z_ack_o, tex_ack_o, busy_o, err_o} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: cyc,stb,we,zack,tack,busy,err=%b, required 0000000",
                     {cyc_o, stb_o, we_o, z_ack_o, tex_ack_o, busy_o, err_o});
        end
        n_checks++;
        if (adr_o !== 32'h0 || sel_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_adr_sel: adr=%h sel=%h, required 0 0", adr_o, sel_o);
        end
        n_checks++;
        if (z_data_o !== 256'h0 || tex_data_o !== 256'h0) begin
            n_errors++;
            $display("FAIL reset_data: z=%h tex=%h, required 0", z_data_o, tex_data_o);
        end
        rst_i = 1'b0;
        step();
        n_checks++;
        if ({cyc_o, busy_o, z_ack_o, tex_ack_o} !== 4'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: cyc,busy,zack,tack=%b, required 0000", {cyc_o, busy_o, z_ack_o, tex_ack_o});
        end
    endtask

    task automatic test_miss_fill();
        bit ok;
        bit held;
        int tex_base;
        tex_base = tex_ack_cnt;
        z_addr_i = 32'h0000_1040;
        z_sel_i  = 32'hF0F0_1234;
        push_exp(1'b0, pat(1), 1'b0);
        z_request_i = 1'b1;
        wait_stb(ok);
        if (ok) begin
            n_checks++;
            if (adr_o !== 32'h0000_1040 || sel_o !== 32'hF0F0_1234 || busy_o !== 1'b1) begin
                n_errors++;
                $display("FAIL miss_adr_sel: adr=%h sel=%h busy=%b, required 00001040 f0f01234 1", adr_o, sel_o, busy_o);
            end
            held = 1'b1;
            repeat (2) begin
                step();
                if (cyc_o !== 1'b1 || stb_o !== 1'b1 || adr_o !== 32'h0000_1040) held = 1'b0;
            end
            n_checks++;
            if (!held) begin
                n_errors++;
                $display("FAIL miss_hold: cyc=%b stb=%b adr=%h, required 1 1 00001040 until ack_i", cyc_o, stb_o, adr_o);
            end
            bus_respond(1, pat(1), 1'b0, 1'b0);
            n_checks++;
            if (z_ack_o !== 1'b1 || tex_ack_o !== 1'b0 || cyc_o !== 1'b0) begin
                n_errors++;
                $display("FAIL miss_ack: z_ack=%b tex_ack=%b cyc=%b, required 1 0 0", z_ack_o, tex_ack_o, cyc_o);
            end
            z_request_i = 1'b0;
            step();
            n_checks++;
            if (z_ack_o !== 1'b0 || tex_ack_cnt != tex_base) begin
                n_errors++;
                $display("FAIL miss_pulse: z_ack=%b tex_acks=%0d, required 0 %0d", z_ack_o, tex_ack_cnt, tex_base);
            end
        end
    endtask

    task automatic test_hit();
        z_addr_i = 32'h0000_105C;
        push_exp(1'b0, pat(1), 1'b0);
        z_request_i = 1'b1;
        step();
        n_checks++;
        if (z_ack_o !== 1'b1 || cyc_o !== 1'b0 || busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL hit_latency: z_ack=%b cyc=%b busy=%b, required 1 0 1", z_ack_o, cyc_o, busy_o);
        end
        z_request_i = 1'b0;
        step();
        n_checks++;
        if (z_ack_o !== 1'b0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_done: z_ack=%b busy=%b, required 0 0", z_ack_o, busy_o);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int z_base;
        int tex_base;
        logic [31:0] exp_adr;
        logic [31:0] exp_sel;
        rst_i = 1'b1;
        step();
        step();
        rst_i    = 1'b0;
        z_base   = z_ack_cnt;
        tex_base = tex_ack_cnt;
        z_addr_i   = 32'h0000_2000;
        z_sel_i    = 32'hFFFF_FFFF;
        tex_addr_i = 32'h0000_4000;
        tex_sel_i  = 32'h0000_FFFF;
        for (int i = 0; i < 4; i++) push_exp((i % 2) == 1, pat(10 + i), 1'b0);
        z_request_i   = 1'b1;
        tex_request_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_adr = ((i % 2) == 1) ? 32'h0000_4000 : 32'h0000_2000;
            exp_sel = ((i % 2) == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            wait_stb(ok);
            if (!ok) break;
            n_checks++;
            if (adr_o !== exp_adr || sel_o !== exp_sel || busy_o !== 1'b1) begin
                n_errors++;
                $display("FAIL rr_grant%0d: adr=%h sel=%h busy=%b, required %h %h 1", i, adr_o, sel_o, busy_o, exp_adr, exp_sel);
            end
            bus_respond(2, pat(10 + i), 1'b0, 1'b0);
            n_checks++;
            if ({z_ack_o, tex_ack_o} !== (((i % 2) == 1) ? 2'b01 : 2'b10)) begin
                n_errors++;
                $display("FAIL rr_ack%0d: z_ack=%b tex_ack=%b, required %s", i, z_ack_o, tex_ack_o,
                         ((i % 2) == 1) ? "tex" : "z");
            end
            if (i == 3) begin
                z_request_i   = 1'b0;
                tex_request_i = 1'b0;
            end
            step();
            n_checks++;
            if (busy_o !== 1'b0 || cyc_o !== 1'b0) begin
                n_errors++;
                $display("FAIL rr_idle%0d: busy=%b cyc=%b, required 0 0", i, busy_o, cyc_o);
            end
        end
        repeat (3) step();
        n_checks++;
        if (z_ack_cnt - z_base != 2 || tex_ack_cnt - tex_base != 2 || cyc_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_counts: z=%0d tex=%0d cyc=%b, required 2 2 0", z_ack_cnt - z_base, tex_ack_cnt - tex_base, cyc_o);
        end
    endtask

    task automatic test_invalidate();
        bit ok;
        z_addr_i = 32'h0000_3000;
        z_sel_i  = 32'h1234_5678;
        push_exp(1'b0, pat(20), 1'b0);
        z_request_i = 1'b1;
        wait_stb(ok);
        if (!ok) return;
        bus_respond(2, pat(20), 1'b0, 1'b1);
        n_checks++;
        if (z_ack_o !== 1'b1) begin
            n_errors++;
            $display("FAIL inv_fill_ack: z_ack=%b, required 1", z_ack_o);
        end
        z_request_i = 1'b0;
        step();
        push_exp(1'b0, pat(21), 1'b0);
        z_request_i = 1'b1;
        step();
        n_checks++;
        if (z_ack_o !== 1'b0 || cyc_o !== 1'b1 || adr_o !== 32'h0000_3000) begin
            n_errors++;
            $display("FAIL inv_fill_miss: z_ack=%b cyc=%b adr=%h, required 0 1 00003000", z_ack_o, cyc_o, adr_o);
        end
        bus_respond(2, pat(21), 1'b0, 1'b0);
        z_request_i = 1'b0;
        step();
        push_exp(1'b0, pat(22), 1'b0);
        z_request_i  = 1'b1;
        invalidate_i = 1'b1;
        step();
        invalidate_i = 1'b0;
        n_checks++;
        if (z_ack_o !== 1'b0 || cyc_o !== 1'b1) begin
            n_errors++;
            $display("FAIL inv_idle_miss: z_ack=%b cyc=%b, required 0 1", z_ack_o, cyc_o);
        end
        bus_respond(2, pat(22), 1'b0, 1'b0);
        z_request_i = 1'b0;
        step();
        push_exp(1'b0, pat(22), 1'b0);
        z_request_i = 1'b1;
        step();
        n_checks++;
        if (z_ack_o !== 1'b1 || cyc_o !== 1'b0) begin
            n_errors++;
            $display("FAIL inv_refill_hit: z_ack=%b cyc=%b, required 1 0", z_ack_o, cyc_o);
        end
        z_request_i = 1'b0;
        step();
    endtask

    task automatic test_bus_error();
        bit ok;
        tex_addr_i = 32'h0000_6000;
        tex_sel_i  = 32'h0F0F_0F0F;
        push_exp(1'b1, 256'h0, 1'b1);
        tex_request_i = 1'b1;
        wait_stb(ok);
        if (!ok) return;
        n_checks++;
        if (adr_o !== 32'h0000_6000 || sel_o !== 32'h0F0F_0F0F) begin
            n_errors++;
            $display("FAIL err_adr: adr=%h sel=%h, required 00006000 0f0f0f0f", adr_o, sel_o);
        end
        bus_respond(2, pat(30), 1'b1, 1'b0);
        n_checks++;
        if (tex_ack_o !== 1'b1 || err_o !== 1'b1 || tex_data_o !== 256'h0 || z_ack_o !== 1'b0) begin
            n_errors++;
            $display("FAIL err_term: tex_ack=%b err=%b z_ack=%b tex_data=%h, required 1 1 0 0",
                     tex_ack_o, err_o, z_ack_o, tex_data_o);
        end
        tex_request_i = 1'b0;
        step();
        n_checks++;
        if (err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL err_pulse: err=%b, required 0", err_o);
        end
        push_exp(1'b0, pat(22), 1'b0);
        z_request_i = 1'b1;
        step();
        n_checks++;
        if (z_ack_o !== 1'b1 || cyc_o !== 1'b0) begin
            n_errors++;
            $display("FAIL err_buf_kept: z_ack=%b cyc=%b, required 1 0", z_ack_o, cyc_o);
        end
        z_request_i = 1'b0;
        step();
        push_exp(1'b1, pat(31), 1'b0);
        tex_request_i = 1'b1;
        step();
        n_checks++;
        if (tex_ack_o !== 1'b0 || cyc_o !== 1'b1 || adr_o !== 32'h0000_6000) begin
            n_errors++;
            $display("FAIL err_retry_miss: tex_ack=%b cyc=%b adr=%h, required 0 1 00006000", tex_ack_o, cyc_o, adr_o);
        end
        bus_respond(2, pat(31), 1'b0, 1'b0);
        tex_request_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_bus();
        bit ok;
        bit quiet;
        z_addr_i = 32'h0000_7000;
        z_request_i = 1'b1;
        wait_stb(ok);
        if (!ok) return;
        rst_i = 1'b1;
        step();
        n_checks++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || z_data_o !== 256'h0 || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_bus_drop: cyc=%b stb=%b busy=%b z_data=%h, required 0 0 0 0", cyc_o, stb_o, busy_o, z_data_o);
        end
        rst_i       = 1'b0;
        z_request_i = 1'b0;
        ack_i       = 1'b1;
        dat_i       = pat(40);
        step();
        ack_i = 1'b0;
        dat_i = '0;
        quiet = 1'b1;
        repeat (4) begin
            step();
            if (z_ack_o !== 1'b0 || tex_ack_o !== 1'b0 || cyc_o !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_errors++;
            $display("FAIL rst_late_ack: z_ack=%b tex_ack=%b cyc=%b, required no ack and no cycle", z_ack_o, tex_ack_o, cyc_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_round_robin();
        test_invalidate();
        test_bus_error();
        test_reset_mid_bus();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expected acks never arrived, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gfx256_wbm_read_arb.md
Name: gfx256_wbm_read_arb

Overview:
Wishbone master read engine that serves the z-buffer read port of the clip stage and the texture read port of the fragment stage.
- Arbitrates the two requesters onto one 256-bit Wishbone classic read bus.
- Holds a one-line read buffer so repeated reads of the same 32-byte line complete without a bus cycle.
- Returns a full 256-bit line; each requester extracts its own pixel.
- Sits between the pixel pipeline and the memory-side Wishbone interconnect.

Parameters:
SW, 256, data bus width in bits; fixed at 256 (line = 32 bytes).
LINE_BUF_EN, 1'b1, enables the one-line read buffer; 0 forces every read to the bus.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
z_request_i  in  1  z read request, level, held until z_ack_o
z_addr_i  in  32  z byte address; bits [4:0] ignored
z_sel_i  in  32  z byte selects
z_ack_o  out  1  one-cycle z completion pulse
z_data_o  out  256  z read line
tex_request_i  in  1  texture read request, level, held until tex_ack_o
tex_addr_i  in  32  texture byte address; bits [4:0] ignored
tex_sel_i  in  32  texture byte selects
tex_ack_o  out  1  one-cycle texture completion pulse
tex_data_o  out  256  texture read line
invalidate_i  in  1  clears line buffer valid (pulse after any writer touches memory)
busy_o  out  1  engine not idle
err_o  out  1  one-cycle pulse on Wishbone error termination
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  tied 0
adr_o  out  32  {addr[31:5],5'b0}
sel_o  out  32  byte selects of the granted requester
dat_i  in  256  Wishbone read data
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone error

Behaviour:
- Reset values:
  - All outputs 0, including z_data_o and tex_data_o.
  - Line buffer valid = 0.
  - last_grant = tex, so the first tie is granted to z.
  - State = IDLE.
- State machine IDLE -> BUS -> DONE -> IDLE. A hit goes IDLE -> DONE.
- IDLE:
  - Only one requester active: grant it.
  - Both active: grant the requester not served last (round-robin).
  - Latch the granted address, selects and requester id.
  - Hit (LINE_BUF_EN, valid, tag = addr[31:5]): next cycle go to DONE. The buffered line drives the granted data output and the granted ack pulses. Latency is 1 cycle.
  - Miss: next cycle cyc_o = stb_o = 1 with adr_o/sel_o driven; go to BUS.
- BUS:
  - Hold cyc_o, stb_o, adr_o and sel_o until ack_i or err_i.
  - On ack_i: drop cyc/stb next edge. Register dat_i into the granted data output and the line buffer (tag updated, valid = 1). Pulse the granted ack the cycle after ack_i. Go to DONE.
  - On err_i: drop cyc/stb. Pulse the granted ack and err_o. Data output = 0. Line buffer unchanged, and valid cleared if its tag matched.
- DONE:
  - One idle cycle; requests are ignored because the requester drops its request the cycle after its ack.
  - Update last_grant. Return to IDLE.
- busy_o = (state != IDLE). It is a registered output.
- Data outputs hold their last value until that port's next ack. The ungranted port's outputs never change.
- invalidate_i:
  - Clears valid in any state.
  - Coincident with a fill on ack_i: invalidate wins (valid = 0), but the requester still gets the fresh data.
  - In IDLE, invalidate_i is evaluated before the hit check, so a same-cycle request misses.
- A request dropped while in BUS does not abort the bus cycle; the data fills the buffer and the ack still pulses (harmless).
- Reset mid-BUS: cyc_o/stb_o go low at the next edge, no ack is issued, and a late ack_i is ignored.
- ack_i or err_i outside BUS is ignored.

Decomposition:
- gfx256_pkg gets:
  - typedef enum logic [1:0] rd_arb_state_e {IDLE, BUS, DONE}
  - typedef enum logic rd_client_e {CLIENT_Z, CLIENT_TEX}
  - localparam LINE_BYTES = 32
- One sub-module, gfx256_line_buf: tag/valid/data register with lookup, fill and invalidate. The arbiter and FSM stay in the top.

Test Plan:
- Reset, then z_request_i with z_addr_i = 32'h0000_1040; bus returns ack_i 3 cycles after stb_o with dat_i = pattern A -> adr_o = 32'h0000_1040, sel_o = z_sel_i, z_ack_o one pulse the cycle after ack_i, z_data_o = A, tex_ack_o stays 0.
- Repeat z read at 32'h0000_105C -> no cyc_o, z_ack_o 1 cycle after request, data = A (buffer hit).
- z and tex requests raised in the same cycle, addresses 32'h2000 and 32'h4000, held continuously -> grants in order z, tex, z, tex; each requester acked exactly once per request; busy_o low only in IDLE.
- invalidate_i pulsed in the same cycle as ack_i for a fill of 32'h3000 -> requester receives data; a following read of 32'h3000 goes to the bus.
- err_i instead of ack_i on a tex read -> tex_ack_o and err_o pulse together, tex_data_o = 0, next read of the same line misses.
- rst_i asserted while cyc_o = 1 -> cyc_o/stb_o = 0 next edge; a late ack_i produces no z_ack_o/tex_ack_o.
